// File: rtl/cmd_encoder.sv
// cmd_encoder: buffers one packet of same-source bytes, then emits it as
// PREFIX, ADDR_AST, SRC, LEN, payload, CRC (payload byte sum) on tx.
module cmd_encoder #(
  parameter logic [7:0] PREFIX      = 8'h55,
  parameter logic [7:0] ADDR_AST    = 8'hAA,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] in_data,
  input  logic [7:0] in_src,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    COLLECT,
    S_PREFIX,
    S_AST,
    S_SRC,
    S_LEN,
    S_DATA,
    S_CRC
  } state_t;

  state_t        state_q;
  logic [7:0]    cnt_q;
  logic [7:0]    rd_q;
  logic [7:0]    crc_q;
  logic [7:0]    src_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    mem [0:255];

  logic [7:0] cnt_d;
  logic [7:0] crc_d;
  logic [7:0] rd_d;
  logic       src_ok;
  logic       acc;
  logic       xfer;
  logic       tmo_hit;
  logic       src_brk;
  logic       close;

  assign src_ok   = (cnt_q == 8'd0) || (in_src == src_q);
  assign in_ready = (state_q == COLLECT) && src_ok;
  assign busy     = (state_q != COLLECT);
  assign acc      = in_valid & in_ready;
  assign xfer     = tx_valid & tx_ready;
  assign cnt_d    = cnt_q + 8'd1;
  assign crc_d    = crc_q + in_data;
  assign rd_d     = rd_q + 8'd1;

  // a foreign source or a long idle gap closes a non-empty packet
  assign src_brk = (cnt_q != 8'd0) && in_valid && !src_ok;
  assign tmo_hit = (cnt_q != 8'd0) && !acc
                && (tmo_q >= TW'(TIMEOUT_CYC - 1));
  assign close   = (acc && (in_last || cnt_q == 8'd254))
                || src_brk || tmo_hit;

  always_ff @(posedge clk) begin
    if (acc) mem[cnt_q] <= in_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= COLLECT;
      cnt_q    <= 8'd0;
      rd_q     <= 8'd0;
      crc_q    <= 8'd0;
      src_q    <= 8'd0;
      tmo_q    <= '0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (acc) begin
            cnt_q <= cnt_d;
            crc_q <= crc_d;
            if (cnt_q == 8'd0) src_q <= in_src;
          end
          if (acc || cnt_q == 8'd0) tmo_q <= '0;
          else if (tmo_q != TW'(TIMEOUT_CYC)) tmo_q <= tmo_q + TW'(1);
          if (close) begin
            state_q  <= S_PREFIX;
            tx_data  <= PREFIX;
            tx_valid <= 1'b1;
            tmo_q    <= '0;
          end
        end
        S_PREFIX: if (xfer) begin
          state_q <= S_AST;
          tx_data <= ADDR_AST;
        end
        S_AST: if (xfer) begin
          state_q <= S_SRC;
          tx_data <= src_q;
        end
        S_SRC: if (xfer) begin
          state_q <= S_LEN;
          tx_data <= cnt_q;
        end
        S_LEN: if (xfer) begin
          state_q <= S_DATA;
          rd_q    <= 8'd0;
          tx_data <= mem[8'd0];
        end
        S_DATA: if (xfer) begin
          if (rd_q == 8'(cnt_q - 8'd1)) begin
            state_q <= S_CRC;
            tx_data <= crc_q;
          end else begin
            rd_q    <= rd_d;
            tx_data <= mem[rd_d];
          end
        end
        S_CRC: if (xfer) begin
          state_q  <= COLLECT;
          tx_valid <= 1'b0;
          cnt_q    <= 8'd0;
          rd_q     <= 8'd0;
          crc_q    <= 8'd0;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_encoder.sv
// tb_cmd_encoder: directed table of packets plus hand-written sequences
// for length wrap, source switch, timeout and mid-frame reset.
module tb_cmd_encoder;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic [7:0] in_src = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       tx_ready = 1'b0;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;

  cmd_encoder #(
    .PREFIX     (8'h55),
    .ADDR_AST   (8'hAA),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .in_data (in_data),
    .in_src  (in_src),
    .in_valid(in_valid),
    .in_last (in_last),
    .in_ready(in_ready),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] src;
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         mode;
    logic [7:0] crc;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_mode = 0;
  int hold_bad = 0;
  int run = 0;
  int last_run = 0;
  logic       pend = 1'b0;
  logic [7:0] pend_d = 8'd0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pay[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        pend = 1'b0;
        run  = 0;
      end else begin
        if (pend && (!tx_valid || tx_data !== pend_d)) hold_bad++;
        pend   = tx_valid && !tx_ready;
        pend_d = tx_data;
        if (tx_valid && tx_ready) got_q.push_back(tx_data);
        if (tx_valid) run++;
        else if (run > 0) begin
          last_run = run;
          run = 0;
        end
      end
    end
  end

  task automatic push(input logic [7:0] s, input logic [7:0] d,
                      input logic l);
    int k = 0;
    in_src = s;
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 3000) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic add_frame(input logic [7:0] s, input logic [7:0] crc);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back(s);
    exp_q.push_back(8'(pay.size()));
    foreach (pay[i]) exp_q.push_back(pay[i]);
    exp_q.push_back(crc);
    pay.delete();
  endtask

  task automatic check_frame(input string nm);
    int k = 0;
    while (got_q.size() < exp_q.size() && k < 5000) begin
      @(posedge clk);
      k++;
    end
    repeat (10) @(posedge clk);
    #1;
    chk({nm, "_len"}, got_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got_q.size())
        chk($sformatf("%s[%0d]", nm, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{8'h03, 3, 8'h01, 8'h02, 8'h03, 0, 8'h06};
    tbl[1] = '{8'h03, 3, 8'h01, 8'h02, 8'h03, 1, 8'h06};
    tbl[2] = '{8'h07, 1, 8'hA5, 8'h00, 8'h00, 0, 8'hA5};
    tbl[3] = '{8'h09, 2, 8'hF0, 8'h20, 8'h00, 0, 8'h10};
    tbl[4] = '{8'h00, 3, 8'h80, 8'h80, 8'h01, 2, 8'h01};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      logic [7:0] b [3];
      rdy_mode = tbl[i].mode;
      b[0] = tbl[i].b0;
      b[1] = tbl[i].b1;
      b[2] = tbl[i].b2;
      for (int j = 0; j < tbl[i].n; j++) begin
        pay.push_back(b[j]);
        push(tbl[i].src, b[j], j == tbl[i].n - 1);
      end
      chk($sformatf("v%0d_lat_valid", i), tx_valid, 1);
      chk($sformatf("v%0d_lat_data", i), tx_data, 8'h55);
      add_frame(tbl[i].src, tbl[i].crc);
      check_frame($sformatf("v%0d", i));
      if (tbl[i].mode == 0)
        chk($sformatf("v%0d_run", i), last_run, tbl[i].n + 5);
    end

    rdy_mode = 0;
    for (int j = 0; j < 255; j++) begin
      pay.push_back(8'hFF);
      push(8'h01, 8'hFF, 1'b0);
    end
    chk("len255_busy", busy, 1);
    chk("len255_in_ready", in_ready, 0);
    add_frame(8'h01, 8'h01);
    pay.push_back(8'h11);
    push(8'h01, 8'h11, 1'b1);
    add_frame(8'h01, 8'h11);
    check_frame("len255");

    push(8'h02, 8'h10, 1'b0);
    push(8'h02, 8'h20, 1'b0);
    in_src = 8'h05;
    in_data = 8'h30;
    in_last = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("sw_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("sw_busy", busy, 1);
    chk("sw_tx_data", tx_data, 8'h55);
    chk("sw_in_ready2", in_ready, 0);
    push(8'h05, 8'h30, 1'b1);
    pay.push_back(8'h10);
    pay.push_back(8'h20);
    add_frame(8'h02, 8'h30);
    pay.push_back(8'h30);
    add_frame(8'h05, 8'h30);
    check_frame("switch");

    push(8'h04, 8'h7F, 1'b0);
    repeat (TMO - 1) @(posedge clk);
    #1;
    chk("tmo_early", tx_valid, 0);
    @(posedge clk);
    #1;
    chk("tmo_valid", tx_valid, 1);
    chk("tmo_data", tx_data, 8'h55);
    pay.push_back(8'h7F);
    add_frame(8'h04, 8'h7F);
    check_frame("tmo");

    for (int j = 1; j <= 5; j++) push(8'h06, 8'(j), j == 5);
    repeat (5) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    chk("mrst_tx_valid", tx_valid, 0);
    chk("mrst_busy", busy, 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    chk("mrst_in_ready", in_ready, 1);
    got_q.delete();
    @(posedge clk);
    #1;
    push(8'h08, 8'h33, 1'b0);
    push(8'h08, 8'h44, 1'b1);
    pay.push_back(8'h33);
    pay.push_back(8'h44);
    add_frame(8'h08, 8'h77);
    check_frame("mrst");

    chk("hold_stable", hold_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
